// File: rtl/ahbl_mem_copier_pkg.sv
// rtl/ahbl_mem_copier_pkg.sv - AHB-Lite encodings and copier FSM state type
package ahbl_mem_copier_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    // RD_A : read address phase on the bus
    // WR_A : read data phase + write address phase (fill: write address phase only)
    // WR_D : write data phase + next read address phase (or IDLE on the last word)
    // ERR  : waiting out the second cycle of an ERROR response
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_WR_A,
        ST_WR_D,
        ST_ERR
    } copier_state_e;

    // HSIZE encoding for a full-width transfer of the given data bus width
    function automatic logic [2:0] hsize_of(input int w_data);
        return 3'($clog2(w_data / 8));
    endfunction

endpackage

// File: rtl/ahbl_mem_copier_if.sv
// rtl/ahbl_mem_copier_if.sv - AHB-Lite master/slave signal bundle for the memory copier
interface ahbl_mem_copier_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) ();

    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hready, hresp, hrdata
    );

endinterface

// File: rtl/ahbl_mem_copier.sv
// rtl/ahbl_mem_copier.sv - AHB-Lite block copier (optional fill mode under COPIER_FILL_EN)
module ahbl_mem_copier
    import ahbl_mem_copier_pkg::*;
#(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int W_COUNT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_ADDR-1:0]  cfg_src,
    input  logic [W_ADDR-1:0]  cfg_dst,
    input  logic [W_COUNT-1:0] cfg_count,
    input  logic               cfg_start,
`ifdef COPIER_FILL_EN
    input  logic               cfg_fill,
    input  logic [W_DATA-1:0]  cfg_fill_data,
`endif
    output logic               busy,
    output logic               done,
    output logic               err,
    ahbl_mem_copier_if.master  ahblm
);

    localparam logic [W_ADDR-1:0] WORD_BYTES = W_ADDR'(W_DATA / 8);
    localparam logic [W_ADDR-1:0] ALIGN_MASK = ~W_ADDR'((W_DATA / 8) - 1);

    copier_state_e      state_q, state_d;
    logic [W_ADDR-1:0]  src_q, src_d;
    logic [W_ADDR-1:0]  dst_q, dst_d;
    logic [W_COUNT-1:0] cnt_q, cnt_d;
    logic [W_ADDR-1:0]  haddr_q, haddr_d;
    logic [1:0]         htrans_q, htrans_d;
    logic               hwrite_q, hwrite_d;
    logic [W_DATA-1:0]  hwdata_q, hwdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               fill_q, fill_d;

    logic               start_fill;
    logic [W_DATA-1:0]  start_fill_data;
    logic [W_ADDR-1:0]  src_al;
    logic [W_ADDR-1:0]  dst_al;
    logic [W_COUNT-1:0] cnt_dec;

`ifdef COPIER_FILL_EN
    assign start_fill      = cfg_fill;
    assign start_fill_data = cfg_fill_data;
`else
    assign start_fill      = 1'b0;
    assign start_fill_data = '0;
`endif

    assign src_al  = cfg_src & ALIGN_MASK;
    assign dst_al  = cfg_dst & ALIGN_MASK;
    assign cnt_dec = cnt_q - W_COUNT'(1);

    // Register every piece of state; bus outputs come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fill_q   <= fill_d;
        end
    end

    // Next-state and next bus-phase values; nothing moves while HREADY is low,
    // except that an ERROR response drops the pending transfer immediately
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        done_d   = 1'b0;
        err_d    = err_q;
        fill_d   = fill_q;

        if ((state_q != ST_IDLE) && (state_q != ST_ERR) && ahblm.hresp) begin
            state_d  = ST_ERR;
            htrans_d = HTRANS_IDLE;
            hwrite_d = 1'b0;
        end else if (ahblm.hready) begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        err_d = 1'b0;
                        if (cfg_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            src_d    = src_al;
                            dst_d    = dst_al;
                            cnt_d    = cfg_count;
                            fill_d   = start_fill;
                            htrans_d = HTRANS_NONSEQ;
                            if (start_fill) begin
                                state_d  = ST_WR_A;
                                haddr_d  = dst_al;
                                hwrite_d = 1'b1;
                                hwdata_d = start_fill_data;
                            end else begin
                                state_d  = ST_RD_A;
                                haddr_d  = src_al;
                                hwrite_d = 1'b0;
                            end
                        end
                    end
                end
                ST_RD_A: begin
                    state_d  = ST_WR_A;
                    haddr_d  = dst_q;
                    hwrite_d = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                end
                ST_WR_A: begin
                    dst_d = dst_q + WORD_BYTES;
                    cnt_d = cnt_dec;
                    if (fill_q) begin
                        // Fill streams writes back to back until the last one
                        if (cnt_dec != '0) begin
                            haddr_d  = dst_q + WORD_BYTES;
                            hwrite_d = 1'b1;
                            htrans_d = HTRANS_NONSEQ;
                        end else begin
                            state_d  = ST_WR_D;
                            hwrite_d = 1'b0;
                            htrans_d = HTRANS_IDLE;
                        end
                    end else begin
                        hwdata_d = ahblm.hrdata;
                        src_d    = src_q + WORD_BYTES;
                        state_d  = ST_WR_D;
                        hwrite_d = 1'b0;
                        if (cnt_dec != '0) begin
                            haddr_d  = src_q + WORD_BYTES;
                            htrans_d = HTRANS_NONSEQ;
                        end else begin
                            htrans_d = HTRANS_IDLE;
                        end
                    end
                end
                ST_WR_D: begin
                    if (cnt_q != '0) begin
                        state_d  = ST_WR_A;
                        haddr_d  = dst_q;
                        hwrite_d = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                    end else begin
                        state_d  = ST_IDLE;
                        hwrite_d = 1'b0;
                        htrans_d = HTRANS_IDLE;
                        done_d   = 1'b1;
                    end
                end
                ST_ERR: begin
                    state_d  = ST_IDLE;
                    htrans_d = HTRANS_IDLE;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end
                default: begin
                    state_d  = ST_IDLE;
                    htrans_d = HTRANS_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign err  = err_q;

    assign ahblm.haddr     = haddr_q;
    assign ahblm.hwrite    = hwrite_q;
    assign ahblm.htrans    = htrans_q;
    assign ahblm.hwdata    = hwdata_q;
    assign ahblm.hsize     = hsize_of(W_DATA);
    assign ahblm.hburst    = HBURST_SINGLE;
    assign ahblm.hprot     = HPROT_DATA;
    assign ahblm.hmastlock = 1'b0;

endmodule

// File: tb/tb_ahbl_mem_copier.sv
// tb/tb_ahbl_mem_copier.sv - directed bench: SRAM slave with wait/error injection and write scoreboard
module tb_ahbl_mem_copier;
    import ahbl_mem_copier_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_src;
    logic [31:0] cfg_dst;
    logic [15:0] cfg_count;
    logic        cfg_start;
`ifdef COPIER_FILL_EN
    logic        cfg_fill;
    logic [31:0] cfg_fill_data;
`endif
    logic        busy;
    logic        done;
    logic        err;

    ahbl_mem_copier_if #(.W_ADDR(32), .W_DATA(32)) ahb ();

    ahbl_mem_copier #(.W_ADDR(32), .W_DATA(32), .W_COUNT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_src       (cfg_src),
        .cfg_dst       (cfg_dst),
        .cfg_count     (cfg_count),
        .cfg_start     (cfg_start),
`ifdef COPIER_FILL_EN
        .cfg_fill      (cfg_fill),
        .cfg_fill_data (cfg_fill_data),
`endif
        .busy          (busy),
        .done          (done),
        .err           (err),
        .ahblm         (ahb)
    );

    always #5 clk = ~clk;

    // Slave model state
    logic [31:0] mem [0:1023];
    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;
    logic        hready_r;
    logic        hresp_r;
    logic        pre_we = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_val = '0;
    logic        rand_en = 1'b0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    logic [63:0] obs_q [$];
    logic [63:0] exp_q [$];

    logic [1:0]  p_htrans;
    logic [31:0] p_haddr;
    logic        p_hwrite;
    logic        p_hready;
    logic        p_hresp;
    int          stall_viol = 0;
    int          bad_trans = 0;

    int errors = 0;
    int checks = 0;

    assign ahb.hready = hready_r;
    assign ahb.hresp  = hresp_r;
    assign ahb.hrdata = (dp_valid && !dp_write) ? mem[dp_addr[11:2]] : 32'h0;

    // Zero-wait SRAM slave with optional random wait states and a two-cycle ERROR on one write address
    always @(posedge clk) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            hready_r <= 1'b1;
            hresp_r  <= 1'b0;
        end else begin
            if (pre_we) mem[pre_addr[11:2]] <= pre_val;
            if (hready_r) begin
                if (dp_valid && dp_write && !hresp_r) begin
                    mem[dp_addr[11:2]] <= ahb.hwdata;
                    obs_q.push_back({dp_addr, ahb.hwdata});
                end
                dp_valid <= (ahb.htrans == HTRANS_NONSEQ);
                dp_write <= ahb.hwrite;
                dp_addr  <= ahb.haddr;
                if (ahb.htrans == HTRANS_NONSEQ && err_en && ahb.hwrite && ahb.haddr == err_addr) begin
                    hready_r <= 1'b0;
                    hresp_r  <= 1'b1;
                end else if (ahb.htrans == HTRANS_NONSEQ && rand_en) begin
                    hready_r <= 1'($urandom_range(0, 1));
                    hresp_r  <= 1'b0;
                end else begin
                    hready_r <= 1'b1;
                    hresp_r  <= 1'b0;
                end
            end else if (hresp_r) begin
                hready_r <= 1'b1;
            end else begin
                hready_r <= rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Bus protocol watch: address phase frozen across wait states, only IDLE/NONSEQ used
    always @(posedge clk) begin
        p_htrans <= ahb.htrans;
        p_haddr  <= ahb.haddr;
        p_hwrite <= ahb.hwrite;
        p_hready <= ahb.hready;
        p_hresp  <= ahb.hresp;
        if (!rst && p_hready === 1'b0 && p_hresp === 1'b0 &&
            (ahb.htrans !== p_htrans || ahb.haddr !== p_haddr || ahb.hwrite !== p_hwrite))
            stall_viol <= stall_viol + 1;
        if (!rst && ahb.htrans !== HTRANS_IDLE && ahb.htrans !== HTRANS_NONSEQ)
            bad_trans <= bad_trans + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_val  = v;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        cfg_src   = s;
        cfg_dst   = d;
        cfg_count = n;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic compare_writes(input string tag);
        logic [63:0] o;
        logic [63:0] e;
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '1;
            check({tag, "_write"}, o, e);
        end
        obs_q.delete();
    endtask

    initial begin
        int cyc;
        int n;
        logic any_busy;
        logic any_nonidle;
        logic [31:0] v;

        rst       = 1'b1;
        cfg_src   = '0;
        cfg_dst   = '0;
        cfg_count = '0;
        cfg_start = 1'b0;
`ifdef COPIER_FILL_EN
        cfg_fill      = 1'b0;
        cfg_fill_data = '0;
`endif
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_haddr",  64'(ahb.haddr),  64'h0);
        check("rst_htrans", 64'(ahb.htrans), 64'(HTRANS_IDLE));
        check("rst_hwrite", 64'(ahb.hwrite), 64'h0);
        check("rst_hwdata", 64'(ahb.hwdata), 64'h0);
        check("rst_busy",   64'(busy), 64'h0);
        check("rst_done",   64'(done), 64'h0);
        check("rst_err",    64'(err),  64'h0);
        check("const_hsize",     64'(ahb.hsize),     64'(HSIZE_WORD));
        check("const_hburst",    64'(ahb.hburst),    64'h0);
        check("const_hprot",     64'(ahb.hprot),     64'h3);
        check("const_hmastlock", 64'(ahb.hmastlock), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-word copy at zero wait
        for (int i = 0; i < 4; i++) begin
            preload(32'h100 + 32'(4 * i), 32'(i + 1));
            exp_q.push_back({32'h200 + 32'(4 * i), 32'(i + 1)});
        end
        obs_q.delete();
        start(32'h100, 32'h200, 16'd4);
        check("copy4_busy", 64'(busy), 64'h1);
        wait_done(cyc);
        check("copy4_cycles", 64'(cyc), 64'd9);
        check("copy4_err", 64'(err), 64'h0);
        @(negedge clk);
        check("copy4_done_pulse", 64'(done), 64'h0);
        check("copy4_idle", 64'(busy), 64'h0);
        compare_writes("copy4");

        // Zero count: done next cycle, no bus activity, never busy
        start(32'h100, 32'h600, 16'd0);
        check("cnt0_done", 64'(done), 64'h1);
        any_busy    = busy;
        any_nonidle = (ahb.htrans != HTRANS_IDLE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_busy    = any_busy | busy;
            any_nonidle = any_nonidle | (ahb.htrans != HTRANS_IDLE);
            if (i == 0) check("cnt0_done_pulse", 64'(done), 64'h0);
        end
        check("cnt0_busy", 64'(any_busy), 64'h0);
        check("cnt0_htrans", 64'(any_nonidle), 64'h0);
        check("cnt0_nwrites", 64'(obs_q.size()), 64'h0);

        // 16-word copy under random wait states, unaligned start addresses
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            preload(32'h400 + 32'(4 * i), v);
            exp_q.push_back({32'h800 + 32'(4 * i), v});
        end
        obs_q.delete();
        rand_en = 1'b1;
        start(32'h402, 32'h801, 16'd16);
        wait_done(cyc);
        rand_en = 1'b0;
        check("rand_done", 64'(done), 64'h1);
        check("rand_err", 64'(err), 64'h0);
        @(negedge clk);
        compare_writes("rand");
        check("rand_stall_stable", 64'(stall_viol), 64'h0);

        // Error response on the 3rd write of an 8-word copy
        for (int i = 0; i < 8; i++) begin
            preload(32'h500 + 32'(4 * i), 32'h1000 + 32'(i));
            preload(32'h900 + 32'(4 * i), 32'hA5A50000 + 32'(i));
        end
        exp_q.push_back({32'h900, 32'h1000});
        exp_q.push_back({32'h904, 32'h1001});
        obs_q.delete();
        err_en   = 1'b1;
        err_addr = 32'h908;
        start(32'h500, 32'h900, 16'd8);
        wait_done(cyc);
        check("errx_cycles", 64'(cyc), 64'd8);
        check("errx_done", 64'(done), 64'h1);
        check("errx_err", 64'(err), 64'h1);
        check("errx_htrans", 64'(ahb.htrans), 64'(HTRANS_IDLE));
        any_nonidle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_nonidle = any_nonidle | (ahb.htrans != HTRANS_IDLE);
        end
        err_en = 1'b0;
        check("errx_no_more_trans", 64'(any_nonidle), 64'h0);
        check("errx_err_held", 64'(err), 64'h1);
        check("errx_busy", 64'(busy), 64'h0);
        compare_writes("errx");
        check("errx_dst2_untouched", 64'(mem[32'h908 >> 2]), 64'hA5A50002);
        check("errx_dst7_untouched", 64'(mem[32'h91C >> 2]), 64'hA5A50007);

        // Start pulsed mid-copy with other addresses is ignored
        preload(32'hB00, 32'h5A5A5A5A);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({32'hA00 + 32'(4 * i), 32'(i + 1)});
        obs_q.delete();
        start(32'h100, 32'hA00, 16'd4);
        check("mid_err_cleared", 64'(err), 64'h0);
        n = 0;
        @(negedge clk);
        n++;
        start(32'h500, 32'hB00, 16'd2);
        n++;
        wait_done(cyc);
        check("mid_cycles", 64'(n + cyc), 64'd9);
        check("mid_err", 64'(err), 64'h0);
        @(negedge clk);
        compare_writes("mid");
        check("mid_other_dst", 64'(mem[32'hB00 >> 2]), 64'h5A5A5A5A);

`ifdef COPIER_FILL_EN
        // Fill mode: back-to-back writes of a constant
        for (int i = 0; i < 5; i++)
            exp_q.push_back({32'h300 + 32'(4 * i), 32'hDEADBEEF});
        obs_q.delete();
        cfg_fill      = 1'b1;
        cfg_fill_data = 32'hDEADBEEF;
        start(32'h100, 32'h300, 16'd5);
        cfg_fill      = 1'b0;
        cfg_fill_data = '0;
        wait_done(cyc);
        check("fill_cycles", 64'(cyc), 64'd6);
        check("fill_err", 64'(err), 64'h0);
        @(negedge clk);
        compare_writes("fill");
`endif

        check("htrans_legal", 64'(bad_trans), 64'h0);
        check("stall_stable_all", 64'(stall_viol), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
